stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_stack_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// LIFO stack controller sitting in front of a single-port synchronous RAM.
// Commands complete with a one-cycle rsp_valid pulse and carry an error bit.

module stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,

    output logic             rsp_valid_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] rsp_data_o,

    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_ovf_o,
    output logic             err_unf_o,
    input  logic             clr_err_i,

    output logic [AW-1:0]    mem_addr_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    // state   | meaning
    // IDLE    | ready for a command
    // WRITE   | PUSH: RAM write strobe asserted
    // READ    | POP/PEEK: read address presented to RAM
    // CAPTURE | POP/PEEK: RAM data captured into rsp_data
    // RESP    | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;

    generate
        if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("stack_ctrl: DEPTH must be a power of two in 2..1024");
        end
    endgenerate

    state_t           state_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    count_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             err_ovf_q;
    logic             err_unf_q;
    logic [AW-1:0]    mem_addr_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_wdata_q;

    logic full;
    logic empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_PUSH;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;

            // Clear first so that an error raised on this same edge wins.
            if (clr_err_i) begin
                err_ovf_q <= 1'b0;
                err_unf_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid_i && cmd_ready_q) begin
                        op_q        <= cmd_op_i;
                        cmd_ready_q <= 1'b0;
                        case (cmd_op_i)
                            OP_PUSH: begin
                                if (full) begin
                                    err_ovf_q   <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_valid_q <= 1'b1;
                                    state_q     <= S_RESP;
                                end else begin
                                    mem_we_q    <= 1'b1;
                                    mem_addr_q  <= count_q[AW-1:0];
                                    mem_wdata_q <= cmd_data_i;
                                    state_q     <= S_WRITE;
                                end
                            end
                            OP_POP, OP_PEEK: begin
                                if (empty) begin
                                    err_unf_q   <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_valid_q <= 1'b1;
                                    state_q     <= S_RESP;
                                end else begin
                                    mem_addr_q <= AW'(count_q - CW'(1));
                                    state_q    <= S_READ;
                                end
                            end
                            default: begin
                                count_q     <= '0;
                                rsp_err_q   <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                state_q     <= S_RESP;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    count_q     <= count_q + CW'(1);
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end

                S_READ: begin
                    mem_addr_q <= '0;
                    state_q    <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    rsp_data_q <= mem_rdata_i;
                    if (op_q == OP_POP) begin
                        count_q <= count_q - CW'(1);
                    end
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end

                S_RESP: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign err_ovf_o   = err_ovf_q;
    assign err_unf_o   = err_unf_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: a queue-based stack model predicts every response,
// a per-cycle monitor checks flags and RAM strobes, and literal checks pin the model.

module tb_stack_ctrl;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

    localparam logic [1:0] PUSH  = 2'b00;
    localparam logic [1:0] POP   = 2'b01;
    localparam logic [1:0] PEEK  = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             rsp_valid;
    logic             rsp_err;
    logic [WIDTH-1:0] rsp_data;
    logic [4:0]       count;
    logic             full;
    logic             empty;
    logic             err_ovf;
    logic             err_unf;
    logic             clr_err = 1'b0;
    logic [3:0]       mem_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata = '0;

    logic [WIDTH-1:0] ram [DEPTH];

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [WIDTH-1:0] stk [$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    logic [WIDTH-1:0] m_rdata = '0;
    int               exp_lat;
    int               exp_we;
    bit               exp_err;
    logic [3:0]       exp_waddr = '0;
    logic [WIDTH-1:0] exp_wdata = '0;
    logic [3:0]       exp_raddr = '0;
    int               we_cnt = 0;
    int               last_lat = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_data_o  (rsp_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .err_ovf_o   (err_ovf),
        .err_unf_o   (err_unf),
        .clr_err_i   (clr_err),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // synchronous RAM: read data appears the cycle after the address
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        end else begin
            chk("full_flag",  {31'd0, full},    {31'd0, count == 5'd16});
            chk("empty_flag", {31'd0, empty},   {31'd0, count == 5'd0});
            chk("count_max",  {31'd0, count <= 5'd16}, 32'd1);
            chk("err_ovf",    {31'd0, err_ovf}, {31'd0, m_ovf});
            chk("err_unf",    {31'd0, err_unf}, {31'd0, m_unf});
            if (mem_we) begin
                we_cnt++;
                chk("wr_addr",  {28'd0, mem_addr}, {28'd0, exp_waddr});
                chk("wr_data",  {16'd0, mem_wdata}, {16'd0, exp_wdata});
            end else begin
                chk("wdata_idle", {16'd0, mem_wdata}, 32'd0);
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d, input bit clr = 1'b0);
        int lat;
        @(negedge clk);
        chk("rsp_pulse_width", {31'd0, rsp_valid}, 32'd0);
        chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        clr_err   = clr;
        @(posedge clk);
        we_cnt = 0;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        exp_err = 1'b0;
        exp_we  = 0;
        case (op)
            PUSH: begin
                if (stk.size() == DEPTH) begin
                    exp_err = 1'b1; m_ovf = 1'b1; exp_lat = 1;
                end else begin
                    exp_waddr = 4'(stk.size());
                    exp_wdata = d;
                    stk.push_back(d);
                    exp_lat = 2; exp_we = 1;
                end
            end
            POP, PEEK: begin
                if (stk.size() == 0) begin
                    exp_err = 1'b1; m_unf = 1'b1; exp_lat = 1;
                end else begin
                    exp_raddr = 4'(stk.size() - 1);
                    m_rdata   = stk[stk.size() - 1];
                    if (op == POP) void'(stk.pop_back());
                    exp_lat = 3;
                end
            end
            default: begin
                stk.delete();
                exp_lat = 1;
            end
        endcase
        @(negedge clk);
        cmd_valid = 1'b0;
        clr_err   = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
            if (exp_lat == 3 && lat == 1)
                chk("rd_addr", {28'd0, mem_addr}, {28'd0, exp_raddr});
            @(negedge clk);
            lat++;
        end
        last_lat = lat;
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency",    lat, exp_lat);
            chk("rsp_err",    {31'd0, rsp_err}, {31'd0, exp_err});
            chk("rsp_data",   {16'd0, rsp_data}, {16'd0, m_rdata});
            chk("count",      {27'd0, count}, stk.size());
            chk("resp_addr",  {28'd0, mem_addr}, 32'd0);
            chk("resp_ready", {31'd0, cmd_ready}, 32'd0);
            chk("we_count",   we_cnt, exp_we);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // power-on reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        chk("lit_count_rst", {27'd0, count}, 32'd0);
        chk("lit_empty_rst", {31'd0, empty}, 32'd1);
        chk("lit_rsp_data_rst", {16'd0, rsp_data}, 32'd0);

        // underflow right after reset
        do_cmd(POP, 16'h0000);
        chk("lit_unf_lat", last_lat, 32'd1);
        chk("lit_unf_err", {31'd0, rsp_err}, 32'd1);
        chk("lit_unf_flag", {31'd0, err_unf}, 32'd1);
        pulse_clr();
        chk("lit_unf_cleared", {31'd0, err_unf}, 32'd0);

        // LIFO order and latencies
        do_cmd(PUSH, 16'h1234);
        chk("lit_push_lat", last_lat, 32'd2);
        do_cmd(PUSH, 16'hABCD);
        chk("lit_count2", {27'd0, count}, 32'd2);
        do_cmd(POP, 16'h0000);
        chk("lit_pop_lat", last_lat, 32'd3);
        chk("lit_pop1", {16'd0, rsp_data}, 32'h0000ABCD);
        do_cmd(POP, 16'h0000);
        chk("lit_pop2", {16'd0, rsp_data}, 32'h00001234);
        chk("lit_empty_after_pops", {31'd0, empty}, 32'd1);

        // PEEK leaves count alone; CLEAR empties
        do_cmd(PUSH, 16'h00FF);
        do_cmd(PEEK, 16'h0000);
        do_cmd(PEEK, 16'h0000);
        chk("lit_peek", {16'd0, rsp_data}, 32'h000000FF);
        chk("lit_peek_count", {27'd0, count}, 32'd1);
        do_cmd(CLEAR, 16'h0000);
        chk("lit_clear_lat", last_lat, 32'd1);
        chk("lit_clear_count", {27'd0, count}, 32'd0);
        chk("lit_clear_data_held", {16'd0, rsp_data}, 32'h000000FF);

        // fill to the top, then overflow
        for (int i = 0; i < DEPTH; i++) do_cmd(PUSH, 16'(16'hA000 + i * 16'h0111));
        chk("lit_full", {31'd0, full}, 32'd1);
        do_cmd(PUSH, 16'h5555);
        chk("lit_ovf_err", {31'd0, rsp_err}, 32'd1);
        chk("lit_ovf_flag", {31'd0, err_ovf}, 32'd1);
        chk("lit_ovf_count", {27'd0, count}, 32'd16);
        pulse_clr();
        chk("lit_ovf_cleared", {31'd0, err_ovf}, 32'd0);
        do_cmd(PEEK, 16'h0000);
        chk("lit_top_peek", {16'd0, rsp_data}, 32'h0000AFFF);

        // drain partly, refill to exercise address reuse
        for (int i = 0; i < 10; i++) do_cmd(POP, 16'h0000);
        do_cmd(PUSH, 16'hBEEF);
        do_cmd(PUSH, 16'hCAFE);
        for (int i = 0; i < 8; i++) do_cmd(POP, 16'h0000);
        chk("lit_bottom", {16'd0, rsp_data}, 32'h0000A000);
        do_cmd(POP, 16'h0000);
        do_cmd(PEEK, 16'h0000, 1'b0);

        // clear and new error on the same edge: set wins
        do_cmd(PEEK, 16'h0000, 1'b1);
        chk("lit_set_wins", {31'd0, err_unf}, 32'd1);

        // reset during CAPTURE of a POP with three entries
        do_cmd(PUSH, 16'h0011);
        do_cmd(PUSH, 16'h0022);
        do_cmd(PUSH, 16'h0033);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = POP;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("lit_rst_count", {27'd0, count}, 32'd0);
        chk("lit_rst_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_ready_after_midrst", {31'd0, cmd_ready}, 32'd1);
        chk("lit_midrst_data", {16'd0, rsp_data}, 32'd0);
        chk("lit_midrst_valid", {31'd0, rsp_valid}, 32'd0);

        do_cmd(PUSH, 16'h7777);
        do_cmd(POP, 16'h0000);
        chk("lit_post_rst_pop", {16'd0, rsp_data}, 32'h00007777);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
